// File: rtl/xmit_enrg_trg_pkg.sv
// Shared framing constants and state encodings for the trigger-request link.
// The receiver side imports the same TRG_BITS so both ends agree on frame length.
package xmit_enrg_trg_pkg;

    localparam int   TRG_BITS  = 3;
    localparam logic START_BIT = 1'b1;
    localparam int   GAP_MIN   = 1;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_GAP   = 4'b1000
    } state_e;

endpackage

// File: rtl/xmit_enrg_trg_fifo.sv
// Small synchronous FIFO for trigger words; read data comes from the registered
// storage at the head pointer, and a pop and a write may share one edge even when full.
module xmit_enrg_trg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_wr   = wr_en & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_wr, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; emptiness is carried entirely by count_q.
    always_ff @(posedge Clock) begin
        if (do_wr)
            mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/xmit_enrg_trg.sv
// Energy-detector trigger transmitter: queues 3-bit trigger words and sends each as
// start bit, b2..b0, then GAP low cycles on the registered single-wire request line.
module xmit_enrg_trg
    import xmit_enrg_trg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 1,
    parameter int CNTW  = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                TrgStrobe,
    input  logic [TRG_BITS-1:0] TrgWordIn,
    output logic                TReqOut,
    output logic                Busy,
    output logic                Full,
    output logic [CNTW-1:0]     NDropped
);

    localparam int         GW       = $clog2(GAP + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [1:0] CNT_LAST = 2'(TRG_BITS - 1);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    state_e              state_q, state_d;
    logic [TRG_BITS-1:0] shift_q, shift_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                treq_q, treq_d;
    logic [CNTW-1:0]     drop_q, drop_d;
    logic                pop;
    logic                fifo_full, fifo_empty;
    logic [TRG_BITS-1:0] fifo_rd;

    xmit_enrg_trg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRG_BITS)
    ) u_fifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .wr_en   (TrgStrobe),
        .wr_data (TrgWordIn),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // treq_d is the line level for the state being entered, so TReqOut is a plain flop.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        treq_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd;
                    treq_d  = START_BIT;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                treq_d  = shift_q[TRG_BITS-1];
                shift_d = {shift_q[TRG_BITS-2:0], 1'b0};
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    treq_d  = shift_q[TRG_BITS-1];
                    shift_d = {shift_q[TRG_BITS-2:0], 1'b0};
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd;
                        treq_d  = START_BIT;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A strobe on a popping edge is accepted by the FIFO, so only a true overflow counts.
    always_comb begin
        drop_d = drop_q;
        if (TrgStrobe && fifo_full && !pop)
            drop_d = sat_inc(drop_q);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            treq_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            treq_q  <= treq_d;
            drop_q  <= drop_d;
        end
    end

    assign TReqOut  = treq_q;
    assign Busy     = (state_q != ST_IDLE) | ~fifo_empty;
    assign Full     = fifo_full;
    assign NDropped = drop_q;

endmodule

// File: doc/xmit_enrg_trg.md
Name: xmit_enrg_trg

Overview:
Transmitter side of the energy-detector trigger-primitive link. It sits on the energy detector board and accepts 3-bit trigger words from the local trigger logic. Words are buffered in a small FIFO and serialised onto the single-wire trigger-request line toward the event builder. Each frame is one start bit '1', then 3 data bits MSB first, then a mandatory low gap, which matches the event-builder receiver's framing: it waits for '1', shifts 3 bits, spends 1 cycle in Done, then returns to Wait.

Parameters:
DEPTH, 4, FIFO depth in words; power of 2, range 2..16.
GAP, 1, number of low cycles forced after each frame's last data bit; must be >= 1, because the receiver's Done cycle ignores the line.
CNTW, 8, width of the dropped-word counter.

Ports:
Clock  in  1  system clock, same domain as receiver
Reset  in  1  synchronous, active-high
TrgStrobe  in  1  one-cycle request to send TrgWordIn
TrgWordIn  in  3  trigger bit pattern, sampled when TrgStrobe=1
TReqOut  out  1  serial trigger-request line (registered)
Busy  out  1  1 while a frame or gap is in progress, or FIFO non-empty
Full  out  1  FIFO holds DEPTH words
NDropped  out  CNTW  count of words lost to FIFO full, saturating

Behaviour:
- Reset, sampled on posedge Clock: TReqOut=0, Busy=0, Full=0, NDropped=0, FIFO emptied, state=Idle, shift register=0.
- Reset mid-frame: the line drops low on the next edge and the partial frame is abandoned (the receiver may capture garbage; accepted). All queued words are discarded.
- FIFO write: TrgStrobe=1 and not full stores TrgWordIn at that edge.
- Strobe while full: the word is dropped and NDropped increments, saturating at all-ones.
- Strobe on the same edge as a pop while full: the word is accepted and NDropped is unchanged.
- Word 3'b000 is transmitted like any other value; the start bit delimits the frame.
- State machine; TReqOut is registered and takes the value listed for the state entered.
  - Idle, TReqOut=0: if the FIFO is non-empty, pop the head word into the shift register and go to Start. Otherwise stay in Idle.
  - Start, TReqOut=1: go to Data with Cnt=0.
  - Data, TReqOut=shift[2]: shift left each cycle; Cnt counts 0..2, exiting to Gap after Cnt=2. The bits go out b2, b1, b0.
  - Gap, TReqOut=0: stay GAP cycles, then go to Idle. If the FIFO is non-empty when the gap expires, go directly to Start, popping at that edge.
- Latency: strobe sampled at edge k with an empty FIFO and Idle:
  - word written at edge k;
  - pop, with TReqOut=1, after edge k+1;
  - b2, b1, b0 after edges k+2, k+3, k+4;
  - low from edge k+5 for GAP cycles.
- Back-to-back frames: each frame occupies exactly 4+GAP cycles, so the line is low for exactly GAP cycles between frames.
- Frame timing is independent of further strobes; the FIFO absorbs bursts.
- Busy = (state != Idle) or FIFO non-empty. Full is driven combinationally from the FIFO occupancy counter.
- FIFO pointers wrap modulo DEPTH. The occupancy counter is log2(DEPTH)+1 bits wide.
- Simulation-only $display trace on every non-Idle cycle, in the same format as the receiver trace.

Decomposition:
- Shared package holds:
  - frame constants: TRG_BITS=3, start-bit value 1'b1;
  - one-hot state encodings Idle/Start/Data/Gap;
  - minimum GAP=1.
- The receiver uses the same TRG_BITS constant.
- One sub-module: trg_fifo, a synchronous FIFO with registered read data, parameterised by DEPTH and width. It exposes Full, Empty, write, pop and read data.

Test Plan:
- Reset, then a single strobe with TrgWordIn=3'b101: TReqOut reads 0,1,1,0,1,0 starting the cycle after the strobe edge (idle, start, b2, b1, b0, gap). The idle receiver instance captures TrgWord=101 and pulses its TReqOut once.
- Back-to-back words 3'b111 then 3'b000 on consecutive cycles, GAP=1: the line reads 1,1,1,1,0,1,0,0,0,0. The receiver yields 111, then 000. Busy deasserts after the second gap.
- Burst of 6 strobes on consecutive cycles with DEPTH=4: 5 words are sent, because the first pop frees a slot and allows one write on the pop edge. NDropped=1 and Full was high for at least one cycle.
- Saturation with CNTW=2: hold the FIFO full and strobe 5 extra times. NDropped stops at 3.
- Reset asserted during the Data bit b1 of word 3'b010, with 2 words queued: TReqOut=0 the next cycle, and Busy=0, Full=0, NDropped=0. No further frames are sent.
- GAP=3 with two queued words 3'b011 and 3'b100: exactly 3 low cycles separate the frames. The receiver captures both words correctly.
